// File: rtl/mem_wbuf_pkg.sv
// Shared types and constants for the mem_wbuf posted-write buffer.
// State encoding, buffer entry layout and the default depth.
`timescale 1ns/1ps
package mem_wbuf_pkg;

   localparam int unsigned DEPTH_DEF = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] RDONE = 2'd3;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/mem_wbuf_fifo.sv
// wbuf_fifo: entry storage, pointers, count and full/empty flags for mem_wbuf.
// It also produces an age-ordered address-match vector and the youngest matching data.
`timescale 1ns/1ps
module wbuf_fifo
   import mem_wbuf_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter bit          FWD_EN = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  wbuf_entry_t                  i_entry,
   input  logic                         i_pop,
   input  logic [29:0]                  i_cmp_addr,
   output wbuf_entry_t                  o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [DEPTH-1:0]             o_match,
   output logic [31:0]                  o_fwd_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   wbuf_entry_t   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_idx;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Scan oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      o_match    = '0;
      o_fwd_data = '0;
      w_idx      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + PW'(i);
         if (FWD_EN && (CW'(i) < r_count) && (r_mem[w_idx].addr == i_cmp_addr)) begin
            o_match[i] = 1'b1;
            o_fwd_data = r_mem[w_idx].data;
         end
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_wbuf.sv
// mem_wbuf: posted-write buffer between the core data port and the word-addressed memory bus.
// Define WBUF_FWD_EN to forward loads from buffered stores instead of waiting for the drain.
`timescale 1ns/1ps
module mem_wbuf
   import mem_wbuf_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        proc_write,
   input  logic        proc_read,
   input  logic [29:0] proc_addr,
   input  logic [31:0] proc_wdata,
   output logic [31:0] proc_rdata,
   output logic        proc_stall,
   output logic        mem_write,
   output logic        mem_read,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

`ifdef WBUF_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [1:0]       r_state;
   logic [31:0]      r_rdata_q;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_hit;
   logic [CW-1:0]    w_count;
   logic [DEPTH-1:0] w_match;
   logic [31:0]      w_fwd_data;
   wbuf_entry_t      w_head;
   wbuf_entry_t      w_entry;

   assign w_entry = '{addr: proc_addr, data: proc_wdata};
   // A store is taken whenever there is room, even when a simultaneous load stalls.
   assign w_push  = proc_write && !w_full && !rst;
   assign w_pop   = (r_state == DRAIN) && mem_ready && !rst;
   assign w_hit   = proc_read && (|w_match);

   wbuf_fifo #(
      .DEPTH  (DEPTH),
      .FWD_EN (FWD_EN)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_entry    (w_entry),
      .i_pop      (w_pop),
      .i_cmp_addr (proc_addr),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_match    (w_match),
      .o_fwd_data (w_fwd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rdata_q <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state <= DRAIN;
               end else if (proc_read && !proc_write && !w_hit) begin
                  r_state <= READ;
               end
            end
            DRAIN: begin
               if (mem_ready) begin
                  r_state <= ((w_count > CW'(1)) || w_push) ? DRAIN : IDLE;
               end
            end
            READ: begin
               if (mem_ready) begin
                  r_rdata_q <= mem_rdata;
                  r_state   <= RDONE;
               end
            end
            RDONE:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_write  = (r_state == DRAIN);
      mem_read   = (r_state == READ);
      mem_addr   = '0;
      mem_wdata  = '0;
      proc_rdata = '0;
      if (r_state == DRAIN) begin
         mem_addr  = w_head.addr;
         mem_wdata = w_head.data;
      end else if (r_state == READ) begin
         mem_addr = proc_addr;
      end
      if (r_state == RDONE) begin
         proc_rdata = r_rdata_q;
      end else if (w_hit) begin
         proc_rdata = w_fwd_data;
      end
      proc_stall = rst
                || (proc_write && w_full)
                || (proc_read && (proc_write || !((r_state == RDONE) || w_hit)));
   end

endmodule

// File: tb/tb_mem_wbuf.sv
// Self-checking bench for mem_wbuf: a responding memory model plus a store-ordered scoreboard.
// Loads are expected to return the most recent accepted store to that address (or memory's initial value).
`timescale 1ns/1ps
module tb_mem_wbuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        proc_write = 1'b0;
   logic        proc_read = 1'b0;
   logic [29:0] proc_addr = '0;
   logic [31:0] proc_wdata = '0;
   logic [31:0] proc_rdata;
   logic        proc_stall;
   logic        mem_write;
   logic        mem_read;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int failures = 0;
   int wait_cycles = 0;
   int rd_cnt = 0;
   int both_cnt = 0;

   logic [61:0] exp_q [$];
   logic [61:0] obs_q [$];
   logic [31:0] ram     [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];

   mem_wbuf #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_write (proc_write),
      .proc_read  (proc_read),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [29:0] a);
      return {2'b10, a} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ram_rd(input logic [29:0] a);
      return ram.exists(a) ? ram[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Memory: answers each request after wait_cycles idle cycles with a one-cycle ready pulse.
   initial begin
      int wcnt;
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_write && mem_read) both_cnt++;
         if (rst) begin
            wcnt      = 0;
            mem_ready = 1'b0;
         end else if (mem_write || mem_read) begin
            if (wcnt >= wait_cycles) begin
               mem_ready = 1'b1;
               wcnt      = 0;
               if (mem_write) begin
                  obs_q.push_back({mem_addr, mem_wdata});
                  ram[mem_addr] = mem_wdata;
               end else begin
                  mem_rdata = ram_rd(mem_addr);
                  rd_cnt++;
               end
            end else begin
               mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
         end
      end
   end

   task automatic idle();
      @(posedge clk);
      #1;
      proc_write = 1'b0;
      proc_read  = 1'b0;
      #2;
   endtask

   task automatic do_store(input logic [29:0] a, input logic [31:0] d, output int stalls, output bit ok);
      stalls = 0;
      ok     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         proc_write = 1'b1;
         proc_read  = 1'b0;
         proc_addr  = a;
         proc_wdata = d;
         #2;
         if (!proc_stall) begin
            exp_q.push_back({a, d});
            ref_mem[a] = d;
            ok = 1'b1;
            break;
         end
         stalls++;
      end
   endtask

   task automatic do_load(input logic [29:0] a, output logic [31:0] d, output int stalls, output bit ok);
      stalls = 0;
      ok     = 1'b0;
      d      = '0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         proc_write = 1'b0;
         proc_read  = 1'b1;
         proc_addr  = a;
         #2;
         if (!proc_stall) begin
            d  = proc_rdata;
            ok = 1'b1;
            break;
         end
         stalls++;
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         idle();
         if (obs_q.size() == exp_q.size() && !mem_write) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (proc_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", proc_stall); end
      checks++;
      if ({mem_write, mem_read} !== 2'b00) begin failures++; $display("FAIL reset_req got=%b exp=00", {mem_write, mem_read}); end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      checks++;
      if (proc_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      checks++;
      if (proc_stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%b exp=0", proc_stall); end
   endtask

   task automatic test_single_store();
      int st, hi, bad;
      bit ok;
      wait_cycles = 3;
      do_store(30'h0FF, 32'h168, st, ok);
      checks++;
      if (!ok || st != 0) begin failures++; $display("FAIL single_accept stalls=%0d exp=0", st); end
      hi  = 0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         idle();
         if (mem_write) begin
            hi++;
            if (mem_addr !== 30'h0FF || mem_wdata !== 32'h168) bad++;
         end
         if (proc_stall !== 1'b0) bad++;
      end
      checks++;
      if (hi != 4) begin failures++; $display("FAIL single_wr_cycles got=%0d exp=4", hi); end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL single_bus_content bad_cycles=%0d exp=0", bad); end
      checks++;
      if (obs_q.size() != exp_q.size() || obs_q[obs_q.size()-1] !== {30'h0FF, 32'h168}) begin
         failures++;
         $display("FAIL single_mem_seen got=%0d writes exp=%0d", obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_burst();
      int st, base, bad;
      bit ok;
      logic [29:0] a;
      logic [31:0] d;
      wait_cycles = 5;
      wait_drain(ok);
      base = obs_q.size();
      for (int i = 0; i < 6; i++) begin
         a = 30'($urandom);
         d = $urandom;
         do_store(a, d, st, ok);
         if (i < 4) begin
            checks++;
            if (!ok || st != 0) begin failures++; $display("FAIL burst_nostall idx=%0d stalls=%0d exp=0", i, st); end
         end else if (i == 4) begin
            checks++;
            if (st == 0) begin failures++; $display("FAIL burst_full_stall stalls=%0d exp=>0", st); end
            checks++;
            if (obs_q.size() - base != 1) begin
               failures++;
               $display("FAIL burst_accept_after_pop pops=%0d exp=1", obs_q.size() - base);
            end
         end
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL burst_drain_timeout got=timeout exp=drained"); end
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      end
      checks++;
      if (bad != 0 || obs_q.size() - base != 6) begin
         failures++;
         $display("FAIL burst_order writes=%0d exp=6 misordered=%0d", obs_q.size() - base, bad);
      end
   endtask

   task automatic test_load_fwd();
      int st, r0;
      bit ok;
      logic [31:0] d;
      wait_cycles = 4;
      wait_drain(ok);
      r0 = rd_cnt;
      do_store(30'h0FF, 32'd479001600, st, ok);
      do_load(30'h0FF, d, st, ok);
      checks++;
      if (!ok || d !== 32'd479001600) begin failures++; $display("FAIL raw_load_data got=%0d exp=479001600", d); end
`ifdef WBUF_FWD_EN
      checks++;
      if (st != 0) begin failures++; $display("FAIL fwd_zero_latency stalls=%0d exp=0", st); end
      checks++;
      if (rd_cnt != r0) begin failures++; $display("FAIL fwd_no_mem_read reads=%0d exp=0", rd_cnt - r0); end
`else
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL load_after_drain pending=%0d exp=0", exp_q.size() - obs_q.size());
      end
      checks++;
      if (rd_cnt != r0 + 1) begin failures++; $display("FAIL load_mem_read reads=%0d exp=1", rd_cnt - r0); end
`endif
   endtask

   task automatic test_youngest();
      int st;
      bit ok;
      logic [31:0] d;
      wait_cycles = 6;
      wait_drain(ok);
      do_store(30'h10, 32'd1, st, ok);
      do_store(30'h10, 32'd2, st, ok);
      do_load(30'h10, d, st, ok);
      checks++;
      if (!ok || d !== 32'd2) begin failures++; $display("FAIL youngest_data got=%0d exp=2", d); end
`ifdef WBUF_FWD_EN
      checks++;
      if (st != 0) begin failures++; $display("FAIL youngest_fwd stalls=%0d exp=0", st); end
`endif
   endtask

   task automatic test_load_miss();
      int st, r0;
      bit ok;
      logic [31:0] d;
      wait_drain(ok);
      ram[30'h2A5]     = 32'hD5D;
      ref_mem[30'h2A5] = 32'hD5D;
      wait_cycles = 2;
      r0 = rd_cnt;
      do_load(30'h2A5, d, st, ok);
      checks++;
      if (!ok || st != 4) begin failures++; $display("FAIL miss_stall_cycles got=%0d exp=4", st); end
      checks++;
      if (d !== 32'hD5D) begin failures++; $display("FAIL miss_data got=%h exp=d5d", d); end
      checks++;
      if (rd_cnt != r0 + 1) begin failures++; $display("FAIL miss_mem_reads got=%0d exp=1", rd_cnt - r0); end
      idle();
      checks++;
      if (proc_rdata !== '0) begin failures++; $display("FAIL miss_rdata_one_cycle got=%h exp=0", proc_rdata); end
   endtask

   task automatic test_reset_mid();
      int st, base, bad;
      bit ok;
      wait_drain(ok);
      wait_cycles = 20;
      base = obs_q.size();
      for (int i = 0; i < 3; i++) do_store(30'h200 + 30'(i), $urandom, st, ok);
      idle();
      idle();
      checks++;
      if (mem_write !== 1'b1 || obs_q.size() != base) begin
         failures++;
         $display("FAIL rstmid_setup got=%b exp=1", mem_write);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      checks++;
      if (proc_stall !== 1'b1) begin failures++; $display("FAIL rstmid_stall got=%b exp=1", proc_stall); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      checks++;
      if ({mem_write, mem_read} !== 2'b00) begin failures++; $display("FAIL rstmid_drop got=%b exp=00", {mem_write, mem_read}); end
      bad = 0;
      repeat (4) begin
         idle();
         if (mem_write !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rstmid_flushed write_cycles=%0d exp=0", bad); end
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      ref_mem = ram;
      wait_cycles = 1;
      do_store(30'h3C3, 32'hCAFE_0001, st, ok);
      wait_drain(ok);
      checks++;
      if (!ok || obs_q.size() != base + 1 || obs_q[obs_q.size()-1] !== {30'h3C3, 32'hCAFE_0001}) begin
         failures++;
         $display("FAIL rstmid_after_store writes=%0d exp=%0d", obs_q.size() - base, 1);
      end
   endtask

   task automatic test_random();
      int st, bad;
      bit ok;
      logic [29:0] a;
      logic [31:0] d, e;
      for (int n = 0; n < 60; n++) begin
         wait_cycles = $urandom_range(0, 3);
         a = 30'h100 + 30'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0, 1: begin
               do_store(a, $urandom, st, ok);
               checks++;
               if (!ok) begin failures++; $display("FAIL rand_store_timeout op=%0d got=timeout exp=accept", n); end
            end
            2: begin
               e = ref_rd(a);
               do_load(a, d, st, ok);
               checks++;
               if (!ok || d !== e) begin failures++; $display("FAIL rand_load op=%0d addr=%h got=%h exp=%h", n, a, d, e); end
            end
            default: idle();
         endcase
      end
      wait_drain(ok);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      end
      checks++;
      if (!ok || bad != 0 || obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rand_write_order got=%0d writes exp=%0d misordered=%0d", obs_q.size(), exp_q.size(), bad);
      end
      checks++;
      if (both_cnt != 0) begin failures++; $display("FAIL rw_exclusive got=%0d overlap cycles exp=0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_burst();
      test_load_fwd();
      test_youngest();
      test_load_miss();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wbuf.md
# mem_wbuf

Posted-write buffer between the pipelined MIPS core's data-memory port and the word-addressed data memory bus. CPU stores are accepted in one cycle and drained to memory in order, each held on the bus until the memory acknowledges it. The bus drain is what the result-checking bench snoops at the test port. Loads wait until the buffer is empty, or are forwarded from the buffer when forwarding is compiled in.

## Interface
- DEPTH, 4: buffer entries; power of two, 2..16.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- proc_write  in  1  store request.
- proc_read  in  1  load request, held until the load completes.
- proc_addr  in  30  word address.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data, valid when proc_read && !proc_stall.
- proc_stall  out  1  core must hold its request.
- mem_write  out  1  write request to memory, held until mem_ready.
- mem_read  out  1  read request to memory, held until mem_ready.
- mem_addr  out  30  memory word address.
- mem_wdata  out  32  memory write data (head entry).
- mem_rdata  in  32  memory read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse for the current request.

## Operation
- FIFO of DEPTH {addr, data} entries, with wr_ptr, rd_ptr and count (width clog2(DEPTH+1)). Pointers wrap modulo DEPTH.
- Store accept: proc_write && !proc_stall pushes the entry. Stall on write is count==DEPTH. There is no bypass when the head retires in the same cycle.
- FSM states:
  - IDLE: if count>0, go to DRAIN. Otherwise, if proc_read without a forward hit, go to READ.
  - DRAIN: mem_write=1 with the head entry. On mem_ready, pop the entry; go to DRAIN if count after the pop is >0, else IDLE.
  - READ: mem_read=1 with mem_addr=proc_addr. On mem_ready, capture mem_rdata into rdata_q and go to RDONE.
  - RDONE: proc_stall=0 and proc_rdata=rdata_q. Return to IDLE.
- Load stall: proc_read stalls in every state except RDONE or a forward hit. Stores always drain before a load reaches memory, so there is no RAW hazard.
- mem_write and mem_read are never high together. Each buffered write is presented exactly once, held across wait cycles.
- Stores and entries are pushed while draining. A push and a pop in the same cycle leave count unchanged.
- proc_read && proc_write together is a protocol violation. The write is served and the read stalls.
- Reset mid-operation: the FIFO is flushed, state goes to IDLE, and any in-flight mem request is dropped. The memory model is reset by the same rst.
- Reset values: mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, proc_rdata=0, rdata_q=0, count=0. proc_stall=1 while rst is high.

## Timing
- Store accept to mem_write high: 1 cycle when the buffer is empty and state is IDLE.
- mem_ready at cycle t: pop at edge t. The next entry appears on the bus at t+1 with no bubble, because DRAIN→DRAIN.
- Load miss with an empty buffer: IDLE → READ (+1), wait W cycles, RDONE. Total proc_stall cycles = W+2.
- Forward hit: zero-latency, proc_stall=0 in the same cycle.

## Configuration
- WBUF_FWD_EN defined: a load whose proc_addr matches any valid entry returns the youngest matching entry's data combinationally. The hit holds proc_stall=0 and causes no memory access or drain wait. A load that misses still waits for an empty buffer.
- Undefined: no address compare; every load waits for an empty buffer and then goes through READ.

## Structure
- Shared package mem_wbuf_pkg: the state encoding (IDLE, DRAIN, READ, RDONE), the entry struct {addr[29:0], data[31:0]}, and DEPTH_DEF=4.
- One sub-module, wbuf_fifo: the storage, pointers, count, full/empty flags, and the per-entry address-match vector used for forwarding.
- The FSM and the proc/mem muxing live in mem_wbuf.

## Test plan
- Single store: addr 0x0FF, data 0x168, mem_ready after 3 wait cycles → mem_write is high for exactly 4 cycles with that addr/data, then drops; proc_stall stays 0.
- Burst of 6 stores with DEPTH=4 and mem_ready delayed 5 cycles → the 5th store stalls until the first pop. Memory sees all 6 in order, each presented exactly once.
- Store 0x0FF←479001600, then load 0x0FF (WBUF_FWD_EN) → proc_rdata=479001600 in the same cycle and no mem_read. Without the macro: the drain completes, then READ runs and memory returns 479001600.
- Two stores to 0x10 (1, then 2), then load 0x10 with forwarding → 2 is returned (youngest entry).
- Load miss on an empty buffer with 2 wait cycles, mem_rdata=0xD5D → proc_stall high 4 cycles, then proc_rdata=0xD5D for 1 cycle.
- rst asserted while DRAIN is waiting with count=3 → next cycle mem_write=0, count=0, state IDLE; a subsequent store drains normally.
